// File: rtl/bridge_rx.sv
// -----------------------------------------------------------------------------
// bridge_rx
//   Host-side command parser for the UART bridge. It takes bytes from the UART
//   receiver and decodes ASCII messages into register-core bus transactions:
//     read  : 'R' + NA hex address digits + CR/LF
//     write : 'W' + NA hex address digits + ND hex data digits + CR/LF
//   A well-formed message produces a one-cycle valid_o strobe. A malformed
//   message produces a one-cycle error_o strobe instead.
//
// Ports
//   clk      in   1           system clock, rising edge
//   rst_n    in   1           asynchronous active-low reset
//   data_i   in   8           received byte
//   valid_i  in   1           data_i valid strobe, one cycle per byte
//   addr_o   out  ADDR_WIDTH  transaction address, held until next transaction
//   data_o   out  DATA_WIDTH  write data, changed only by writes
//   rw_o     out  1           0 = read, 1 = write
//   valid_o  out  1           one-cycle transaction strobe
//   error_o  out  1           one-cycle malformed-message strobe
//
// Configuration
//   BRIDGE_RX_LOWERCASE_EN : when defined, 'a'-'f' are accepted as hex digits
//                            and 'r'/'w' are accepted as preambles.
// -----------------------------------------------------------------------------
module bridge_rx #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            data_i,
    input  logic                  valid_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  rw_o,
    output logic                  valid_o,
    output logic                  error_o
);

    localparam int NA   = ADDR_WIDTH / 4;
    localparam int ND   = DATA_WIDTH / 4;
    localparam int MAXD = (NA > ND) ? NA : ND;
    localparam int CW   = $clog2(MAXD + 1);

    localparam logic [CW-1:0] NA_C    = CW'(NA);
    localparam logic [CW-1:0] NA_LAST = CW'(NA - 1);
    localparam logic [CW-1:0] ND_C    = CW'(ND);

    // DONE_R/DONE_W/ERR each last exactly one cycle; they are the cycles in
    // which valid_o or error_o is high.
    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        WADDR,
        WDATA,
        DONE_R,
        DONE_W,
        ERR
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [CW-1:0]           count;
    logic [ADDR_WIDTH-1:0]   addr_sh;
    logic [DATA_WIDTH-1:0]   data_sh;

    logic                    is_hex;
    logic [3:0]              nibble;
    logic                    is_term;
    logic                    is_r;
    logic                    is_w;

    logic                    shift_addr;
    logic                    shift_data;
    logic                    clr_count;
    logic                    inc_count;

    // Byte classification. For letters the low nibble of the ASCII code is
    // 1..6, so adding 9 yields the hex value 10..15.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (data_i >= 8'h30 && data_i <= 8'h39) begin
            is_hex = 1'b1;
            nibble = data_i[3:0];
        end else if (data_i >= 8'h41 && data_i <= 8'h46) begin
            is_hex = 1'b1;
            nibble = data_i[3:0] + 4'd9;
        end
`ifdef BRIDGE_RX_LOWERCASE_EN
        else if (data_i >= 8'h61 && data_i <= 8'h66) begin
            is_hex = 1'b1;
            nibble = data_i[3:0] + 4'd9;
        end
`endif
    end

    assign is_term = (data_i == 8'h0D) || (data_i == 8'h0A);
`ifdef BRIDGE_RX_LOWERCASE_EN
    assign is_r = (data_i == 8'h52) || (data_i == 8'h72);
    assign is_w = (data_i == 8'h57) || (data_i == 8'h77);
`else
    assign is_r = (data_i == 8'h52);
    assign is_w = (data_i == 8'h57);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and datapath control. A preamble always restarts parsing,
    // even mid-message, so the parser resynchronises without flagging an
    // error. The one-cycle DONE/ERR states accept a byte just as IDLE does.
    always_comb begin
        next_state = state;
        shift_addr = 1'b0;
        shift_data = 1'b0;
        clr_count  = 1'b0;
        inc_count  = 1'b0;
        if (state == DONE_R || state == DONE_W || state == ERR) begin
            next_state = IDLE;
        end
        if (valid_i) begin
            if (is_r) begin
                next_state = RADDR;
                clr_count  = 1'b1;
            end else if (is_w) begin
                next_state = WADDR;
                clr_count  = 1'b1;
            end else begin
                case (state)
                    RADDR: begin
                        if (is_hex && count != NA_C) begin
                            shift_addr = 1'b1;
                            inc_count  = 1'b1;
                        end else if (is_term && count == NA_C) begin
                            next_state = DONE_R;
                        end else begin
                            next_state = ERR;
                        end
                    end
                    WADDR: begin
                        if (is_hex) begin
                            shift_addr = 1'b1;
                            if (count == NA_LAST) begin
                                next_state = WDATA;
                                clr_count  = 1'b1;
                            end else begin
                                inc_count = 1'b1;
                            end
                        end else begin
                            next_state = ERR;
                        end
                    end
                    WDATA: begin
                        if (is_hex && count != ND_C) begin
                            shift_data = 1'b1;
                            inc_count  = 1'b1;
                        end else if (is_term && count == ND_C) begin
                            next_state = DONE_W;
                        end else begin
                            next_state = ERR;
                        end
                    end
                    default: begin
                        next_state = IDLE;
                    end
                endcase
            end
        end
    end

    // Digit counter, shadow registers and the held transaction outputs. The
    // outputs load on the terminator accept edge, so they are already valid
    // in the DONE cycle that raises valid_o.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            addr_sh <= '0;
            data_sh <= '0;
            addr_o  <= '0;
            data_o  <= '0;
            rw_o    <= 1'b0;
        end else begin
            if (clr_count) begin
                count <= '0;
            end else if (inc_count) begin
                count <= count + 1'b1;
            end
            if (shift_addr) begin
                addr_sh <= {addr_sh[ADDR_WIDTH-5:0], nibble};
            end
            if (shift_data) begin
                data_sh <= {data_sh[DATA_WIDTH-5:0], nibble};
            end
            if (next_state == DONE_R) begin
                addr_o <= addr_sh;
                rw_o   <= 1'b0;
            end else if (next_state == DONE_W) begin
                addr_o <= addr_sh;
                data_o <= data_sh;
                rw_o   <= 1'b1;
            end
        end
    end

    // Strobe outputs decoded straight from the registered state
    always_comb begin
        valid_o = (state == DONE_R) || (state == DONE_W);
        error_o = (state == ERR);
    end

endmodule
